// File: rtl/ring_buffer_responder_pkg.sv
// ring_buffer_pkg: shared handshake state type and default geometry for the ring buffer responder.
package ring_buffer_pkg;
    typedef enum logic {IDLE, ACK} hs_state_e;
    localparam int DEF_DEPTH = 256;
    localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/ring_buffer_responder_if.sv
// ring_buffer_responder_if: push/pop handshakes, checkpoint controls and status flags.
// RING_BUFFER_STATUS_EN adds used_count/overflow and the DEPTH parameter that sizes them.
interface ring_buffer_responder_if
    import ring_buffer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef RING_BUFFER_STATUS_EN
    , parameter int DEPTH = DEF_DEPTH
`endif
);
    logic             push_request;
    logic [WIDTH-1:0] push_data;
    logic             push_done;
    logic             pop_request;
    logic [WIDTH-1:0] pop_data;
    logic             pop_done;
    logic             open;
    logic             commit;
    logic             rollback;
    logic             empty;
    logic             full;
`ifdef RING_BUFFER_STATUS_EN
    logic [$clog2(DEPTH):0] used_count;
    logic                   overflow;
`endif

    modport slave (
        input  push_request, push_data, pop_request, open, commit, rollback,
        output push_done, pop_data, pop_done, empty, full
`ifdef RING_BUFFER_STATUS_EN
        , output used_count, overflow
`endif
    );

    modport master (
        output push_request, push_data, pop_request, open, commit, rollback,
        input  push_done, pop_data, pop_done, empty, full
`ifdef RING_BUFFER_STATUS_EN
        , input used_count, overflow
`endif
    );
endinterface

// File: rtl/ring_buffer_responder_handshake.sv
// rb_handshake: IDLE/ACK channel FSM; accepts a request when allowed and pulses done one cycle later.
module rb_handshake
    import ring_buffer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic ok_i,
    output logic accept_o,
    output logic done_o
);
    hs_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ACK always returns to IDLE, so a request still held during done is ignored
    always_comb begin
        accept_o = state_q == IDLE && req_i && ok_i;
        done_o   = state_q == ACK;
        state_d  = accept_o ? ACK : IDLE;
    end
endmodule

// File: rtl/ring_buffer_responder.sv
// ring_buffer_responder: ring buffer with push/pop handshakes and checkpoint open/commit/rollback.
// Define RING_BUFFER_STATUS_EN to add used_count and sticky overflow outputs.
module ring_buffer_responder
    import ring_buffer_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    ring_buffer_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, ck_q, ck_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             push_acc, pop_acc;

    rb_handshake u_push (
        .clk(clk), .rst(rst), .req_i(bus.push_request), .ok_i(!bus.full),
        .accept_o(push_acc), .done_o(bus.push_done)
    );

    rb_handshake u_pop (
        .clk(clk), .rst(rst), .req_i(bus.pop_request), .ok_i(!bus.empty),
        .accept_o(pop_acc), .done_o(bus.pop_done)
    );

    // full is measured against the checkpoint so uncommitted pops stay protected
    assign bus.empty    = rd_q == wr_q;
    assign bus.full     = wr_q + AW'(1) == ck_q;
    assign bus.pop_data = pop_data_q;

    always_comb begin
        wr_d       = push_acc ? wr_q + AW'(1) : wr_q;
        rd_d       = bus.rollback ? ck_q : pop_acc ? rd_q + AW'(1) : rd_q;
        ck_d       = bus.rollback ? ck_q : (bus.commit || bus.open) ? rd_q : ck_q;
        pop_data_d = pop_acc ? mem[rd_q] : pop_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            ck_q       <= '0;
            pop_data_q <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            ck_q       <= ck_d;
            pop_data_q <= pop_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_q] <= bus.push_data;
    end

`ifdef RING_BUFFER_STATUS_EN
    logic overflow_q;

    assign bus.used_count = {1'b0, wr_q - ck_q};
    assign bus.overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (rst)                               overflow_q <= 1'b0;
        else if (bus.push_request && bus.full) overflow_q <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_ring_buffer_responder.sv
// tb_ring_buffer_responder: table-driven and hand-sequenced checks of the ring buffer at DEPTH=4.
module tb_ring_buffer_responder;
    import ring_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;
    localparam int NV    = 18;

    typedef enum {OP_PUSH, OP_POP, OP_OPEN, OP_COMMIT, OP_ROLLBACK} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] data;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    vec_t        vecs[NV];

    always #5 clk = ~clk;

`ifdef RING_BUFFER_STATUS_EN
    ring_buffer_responder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus();
`else
    ring_buffer_responder_if #(.WIDTH(WIDTH)) bus();
`endif

    ring_buffer_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs;
        bus.push_request = 1'b0;
        bus.push_data    = '0;
        bus.pop_request  = 1'b0;
        bus.open         = 1'b0;
        bus.commit       = 1'b0;
        bus.rollback     = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check({tag, " reset empty"}, bus.empty, 1);
        check({tag, " reset full"}, bus.full, 0);
        check({tag, " reset push_done"}, bus.push_done, 0);
        check({tag, " reset pop_done"}, bus.pop_done, 0);
        check({tag, " reset pop_data"}, bus.pop_data, 0);
    endtask

    task automatic do_push(input logic [15:0] w, input string tag);
        int n = 0;
        bus.push_request = 1'b1;
        bus.push_data    = w;
        do begin
            tick();
            n++;
        end while (!bus.push_done && n < 20);
        check({tag, " push latency"}, n, 1);
        bus.push_request = 1'b0;
        tick();
    endtask

    task automatic do_pop(input logic [15:0] w, input string tag);
        int n = 0;
        exp_q.push_back(w);
        bus.pop_request = 1'b1;
        do begin
            tick();
            n++;
        end while (!bus.pop_done && n < 20);
        check({tag, " pop latency"}, n, 1);
        if (bus.pop_done) check({tag, " pop data"}, bus.pop_data, exp_q.pop_front());
        else void'(exp_q.pop_front());
        bus.pop_request = 1'b0;
        tick();
    endtask

    task automatic pulse(input op_e op);
        bus.open     = op == OP_OPEN;
        bus.commit   = op == OP_COMMIT;
        bus.rollback = op == OP_ROLLBACK;
        tick();
        bus.open     = 1'b0;
        bus.commit   = 1'b0;
        bus.rollback = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // op, data (push word or expected pop word), expected empty, expected full
        vecs[0]  = '{OP_PUSH,     16'h1111, 1'b0, 1'b0};
        vecs[1]  = '{OP_PUSH,     16'h2222, 1'b0, 1'b0};
        vecs[2]  = '{OP_PUSH,     16'h3333, 1'b0, 1'b1};
        vecs[3]  = '{OP_POP,      16'h1111, 1'b0, 1'b1};
        vecs[4]  = '{OP_POP,      16'h2222, 1'b0, 1'b1};
        vecs[5]  = '{OP_POP,      16'h3333, 1'b1, 1'b1};
        vecs[6]  = '{OP_COMMIT,   16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{OP_PUSH,     16'hAAAA, 1'b0, 1'b0};
        vecs[8]  = '{OP_PUSH,     16'hBBBB, 1'b0, 1'b0};
        vecs[9]  = '{OP_OPEN,     16'h0000, 1'b0, 1'b0};
        vecs[10] = '{OP_POP,      16'hAAAA, 1'b0, 1'b0};
        vecs[11] = '{OP_POP,      16'hBBBB, 1'b1, 1'b0};
        vecs[12] = '{OP_ROLLBACK, 16'h0000, 1'b0, 1'b0};
        vecs[13] = '{OP_PUSH,     16'hCCCC, 1'b0, 1'b1};
        vecs[14] = '{OP_POP,      16'hAAAA, 1'b0, 1'b1};
        vecs[15] = '{OP_COMMIT,   16'h0000, 1'b0, 1'b0};
        vecs[16] = '{OP_POP,      16'hBBBB, 1'b0, 1'b0};
        vecs[17] = '{OP_POP,      16'hCCCC, 1'b1, 1'b0};

        idle_inputs();
        do_reset("initial");

        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                OP_PUSH: do_push(vecs[i].data, $sformatf("vec%0d", i));
                OP_POP:  do_pop(vecs[i].data, $sformatf("vec%0d", i));
                default: pulse(vecs[i].op);
            endcase
            check($sformatf("vec%0d empty", i), bus.empty, vecs[i].exp_empty);
            check($sformatf("vec%0d full", i), bus.full, vecs[i].exp_full);
        end

        // full stall until a pop is committed
        do_reset("stall");
        do_push(16'hA001, "stall1");
        do_push(16'hA002, "stall2");
        do_push(16'hA003, "stall3");
        check("stall full", bus.full, 1);
        bus.push_request = 1'b1;
        bus.push_data    = 16'hA004;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall push_done c%0d", i), bus.push_done, 0);
        end
        bus.pop_request = 1'b1;
        tick();
        check("stall pop_done", bus.pop_done, 1);
        check("stall pop_data", bus.pop_data, 16'hA001);
        check("stall still full", bus.full, 1);
        bus.pop_request = 1'b0;
        bus.commit      = 1'b1;
        tick();
        bus.commit = 1'b0;
        check("stall full after commit", bus.full, 0);
        check("stall push_done at commit", bus.push_done, 0);
        tick();
        check("stall push_done released", bus.push_done, 1);
        bus.push_request = 1'b0;
        tick();
        do_pop(16'hA002, "stall drain2");
        do_pop(16'hA003, "stall drain3");
        do_pop(16'hA004, "stall drain4");
        check("stall drained empty", bus.empty, 1);

        // simultaneous push and pop
        do_reset("simul");
        do_push(16'h5555, "simul pre");
        bus.push_request = 1'b1;
        bus.push_data    = 16'h7777;
        bus.pop_request  = 1'b1;
        tick();
        check("simul push_done", bus.push_done, 1);
        check("simul pop_done", bus.pop_done, 1);
        check("simul pop_data", bus.pop_data, 16'h5555);
        idle_inputs();
        tick();
        do_pop(16'h7777, "simul post");
        check("simul empty", bus.empty, 1);

        // rollback coincident with a pop accept keeps the read pointer
        do_reset("rbpop");
        do_push(16'hB001, "rbpop1");
        do_push(16'hB002, "rbpop2");
        pulse(OP_OPEN);
        bus.pop_request = 1'b1;
        bus.rollback    = 1'b1;
        tick();
        check("rbpop pop_done", bus.pop_done, 1);
        check("rbpop pop_data", bus.pop_data, 16'hB001);
        idle_inputs();
        tick();
        do_pop(16'hB001, "rbpop again");

        // pop waiting on empty, then a push wakes it
        do_reset("wait");
        bus.pop_request = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("wait pop_done c%0d", i), bus.pop_done, 0);
        end
        bus.push_request = 1'b1;
        bus.push_data    = 16'h4444;
        tick();
        check("wait push_done", bus.push_done, 1);
        check("wait pop_done early", bus.pop_done, 0);
        bus.push_request = 1'b0;
        tick();
        check("wait pop_done", bus.pop_done, 1);
        check("wait pop_data", bus.pop_data, 16'h4444);
        bus.pop_request = 1'b0;
        tick();

        // reset during ACK aborts the handshake
        bus.push_request = 1'b1;
        bus.push_data    = 16'h9999;
        tick();
        check("abort push_done in ack", bus.push_done, 1);
        rst = 1'b1;
        tick();
        check("abort push_done", bus.push_done, 0);
        check("abort empty", bus.empty, 1);
        check("abort full", bus.full, 0);
        check("abort pop_data", bus.pop_data, 0);
        rst = 1'b0;
        bus.push_request = 1'b0;
        tick();
        check("abort no late done", bus.push_done, 0);
        check("abort still empty", bus.empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
